// File: rtl/wr_data_drain.sv
// Burst drain stage between the 64-bit write-data FIFO and a valid/ready write-data channel.
// Optional empty-FIFO stall abort is enabled with the WD_DRAIN_TIMEOUT_EN macro.
module wr_data_drain #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              burst_req,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              burst_ack,
  output logic              burst_done,
  output logic              burst_err,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  output logic              wr_last,
  input  logic              wr_ready,
  output logic [LEN_W-1:0]  beat_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StCapt  = 2'd2;
  localparam logic [1:0] StSend  = 2'd3;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] One    = LEN_W'(1);

  // beat_cnt must reach MAX_BURST without wrapping; the stall counter is 8 bits wide.
  if (MAX_BURST < 1 || MAX_BURST >= (1 << LEN_W) || TIMEOUT < 1 || TIMEOUT > 256)
  begin : g_bad_cfg
    $error("wr_data_drain: illegal MAX_BURST/LEN_W/TIMEOUT combination");
  end

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              len_ok;
  logic              timeout;

  assign len_ok = (burst_len != '0) && (burst_len <= MaxLen);

`ifdef WD_DRAIN_TIMEOUT_EN
  localparam logic [7:0] StallMax = 8'(TIMEOUT - 1);

  logic [7:0] stall_q, stall_d;

  // Counts consecutive empty cycles spent in FETCH; any other cycle restarts it.
  always_comb begin
    stall_d = 8'd0;
    if (state_q == StFetch && fifo_empty) begin
      stall_d = stall_q + 8'd1;
    end
  end

  assign timeout = (state_q == StFetch) && fifo_empty && (stall_q == StallMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 8'd0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (burst_req) begin
          if (len_ok) begin
            len_d   = burst_len;
            cnt_d   = '0;
            ack_d   = 1'b1;
            state_d = StFetch;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (!fifo_empty) begin
          state_d = StCapt;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCapt: begin
        // FIFO output is registered: the word popped in FETCH is valid now.
        data_d  = fifo_data;
        valid_d = 1'b1;
        last_d  = (cnt_q == len_q - One);
        state_d = StSend;
      end
      StSend: begin
        if (wr_ready) begin
          cnt_d   = cnt_q + One;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Reading only in FETCH keeps at most one word in flight.
  assign fifo_rd    = (state_q == StFetch) && !fifo_empty;
  assign burst_ack  = ack_q;
  assign burst_done = done_q;
  assign burst_err  = err_q;
  assign wr_data    = data_q;
  assign wr_valid   = valid_q;
  assign wr_last    = last_q;
  assign beat_cnt   = cnt_q;

endmodule
